// File: rtl/spi_image_loader.sv
// Purpose: assembles one bit-packed binary image from the SPI byte stream (command byte, then payload).
// Latency: byte sampled in cycle t -> byte_taken in t+1; last payload byte in t -> image_ready in t+1.
// Backpressure: rx_enable drops and pending bytes stay unacknowledged while a frame awaits img_consumed.
module spi_image_loader #(
    parameter int          IMG_W          = 32,
    parameter int          IMG_H          = 32,
    parameter logic [7:0]  CMD_LOAD       = 8'hA5,
    parameter logic [7:0]  CMD_CLEAR      = 8'hC3,
    parameter int          TIMEOUT_CYCLES = 100000,
    localparam int         IMG_BITS       = IMG_W * IMG_H,
    localparam int         NUM_BYTES      = IMG_BITS / 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          spi_rx_data,
    input  logic                byte_valid,
    output logic                byte_taken,
    output logic                rx_enable,
    output logic [IMG_BITS-1:0] img_bits,
    output logic                image_ready,
    input  logic                img_consumed,
    output logic                frame_err,
    output logic                cmd_err
);

    // Wide enough to hold NUM_BYTES itself, so the count never wraps at the terminal byte.
    localparam int CNT_W = $clog2(NUM_BYTES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READY = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] byte_cnt;
    logic [31:0]      to_cnt;
    logic [1:0]       holdoff;

    logic             accept;
    logic             last_byte;
    logic             timeout_hit;
    logic             load_byte;
    logic             clear_img;
    logic             bad_cmd;
    logic [7:0]       data_rev;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode: accept beats timeout because timeout_hit is qualified by !accept.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && spi_rx_data == CMD_LOAD) begin
                    state_nx = LOAD;
                end
            end
            LOAD: begin
                if (accept && last_byte) begin
                    state_nx = READY;
                end else if (timeout_hit) begin
                    state_nx = IDLE;
                end
            end
            READY: begin
                if (img_consumed) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Per-cycle strobes: byte acceptance, command classification, payload write and timeout.
    always_comb begin
        accept      = byte_valid && (holdoff == 2'd0) && (state == IDLE || state == LOAD);
        last_byte   = (byte_cnt == CNT_W'(NUM_BYTES - 1));
        timeout_hit = (state == LOAD) && !accept && (to_cnt == 32'(TIMEOUT_CYCLES - 1));
        load_byte   = accept && (state == LOAD);
        clear_img   = accept && (state == IDLE) && (spi_rx_data == CMD_CLEAR);
        bad_cmd     = accept && (state == IDLE) && (spi_rx_data != CMD_LOAD)
                      && (spi_rx_data != CMD_CLEAR);
        // Pixels arrive MSB first: byte bit 7 lands on the lowest pixel of its group.
        data_rev = '0;
        for (int b = 0; b < 8; b++) begin
            data_rev[7-b] = spi_rx_data[b];
        end
    end

    // Handshake and status registers; holdoff masks the SPI stage's lagging byte_valid for three cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            holdoff     <= 2'd0;
            byte_taken  <= 1'b0;
            rx_enable   <= 1'b0;
            image_ready <= 1'b0;
            frame_err   <= 1'b0;
            cmd_err     <= 1'b0;
        end else begin
            if (accept) begin
                holdoff <= 2'd3;
            end else if (holdoff != 2'd0) begin
                holdoff <= holdoff - 2'd1;
            end
            byte_taken  <= accept;
            rx_enable   <= (state_nx != READY);
            image_ready <= (state_nx == READY);
            frame_err   <= timeout_hit;
            cmd_err     <= bad_cmd;
        end
    end

    // Payload byte counter and inter-byte timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            to_cnt   <= '0;
        end else begin
            if (state == IDLE && accept && spi_rx_data == CMD_LOAD) begin
                byte_cnt <= '0;
            end else if (load_byte) begin
                byte_cnt <= byte_cnt + CNT_W'(1);
            end else if (timeout_hit) begin
                byte_cnt <= '0;
            end

            if (state != LOAD || accept || timeout_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 32'd1;
            end
        end
    end

    // Image buffer: cleared by CMD_CLEAR, written one byte group per payload byte, frozen otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            img_bits <= '0;
        end else if (clear_img) begin
            img_bits <= '0;
        end else if (load_byte) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (byte_cnt == CNT_W'(k)) begin
                    img_bits[8*k +: 8] <= data_rev;
                end
            end
        end
    end

endmodule
